// File: rtl/read_ctrl_sync_level.sv
// read_ctrl_sync_level: FIFO read-side controller; syncs wptr_async into rclk, owns read pointers, drives rpop/raddr/rptr, registered rempty/ralmost_empty/rlevel and sticky runderflow
module read_ctrl_sync_level #(
  parameter int ADDRESS_SIZE = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    rclk,
  input  logic                    rreset,
  input  logic [ADDRESS_SIZE:0]   wptr_async,
  input  logic                    rinc,
  input  logic [ADDRESS_SIZE:0]   ae_thresh,
  input  logic                    clr_underflow,
  output logic                    rpop,
  output logic [ADDRESS_SIZE-1:0] raddr,
  output logic [ADDRESS_SIZE:0]   rptr,
  output logic                    rempty,
  output logic                    ralmost_empty,
  output logic [ADDRESS_SIZE:0]   rlevel,
  output logic                    runderflow
);
  logic [ADDRESS_SIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRESS_SIZE:0] wptr_sync, wbin_sync, rbin, rbin_next, rgray_next, level_next;
  assign wptr_sync = sync_q[SYNC_STAGES-1];
  for (genvar k = 0; k <= ADDRESS_SIZE; k++) begin : g2b
    assign wbin_sync[k] = ^wptr_sync[ADDRESS_SIZE:k];
  end
  assign rpop       = rinc & ~rempty;
  assign rbin_next  = rbin + {{ADDRESS_SIZE{1'b0}}, rpop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign level_next = wbin_sync - rbin_next;
  assign raddr      = rbin[ADDRESS_SIZE-1:0];
  always_ff @(posedge rclk) begin
    if (rreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
      runderflow    <= 1'b0;
    end else begin
      sync_q[0] <= wptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= rgray_next == wptr_sync;
      ralmost_empty <= level_next <= ae_thresh;
      rlevel        <= level_next;
      runderflow    <= (rinc & rempty) | (runderflow & ~clr_underflow);
    end
  end
endmodule

// File: tb/tb_read_ctrl_sync_level.sv
// tb_read_ctrl_sync_level: directed table plus wrap/full sequences for read_ctrl_sync_level
module tb_read_ctrl_sync_level;
  logic       rclk = 0, rreset, rinc, clr_underflow, rpop, rempty, ralmost_empty, runderflow;
  logic [4:0] wptr_async, ae_thresh, rptr, rlevel;
  logic [3:0] raddr;
  int total = 0, bad = 0;
  read_ctrl_sync_level dut (
    .rclk(rclk), .rreset(rreset), .wptr_async(wptr_async), .rinc(rinc),
    .ae_thresh(ae_thresh), .clr_underflow(clr_underflow), .rpop(rpop), .raddr(raddr),
    .rptr(rptr), .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel),
    .runderflow(runderflow)
  );
  always #5 rclk = ~rclk;
  typedef struct {
    logic rst; logic [4:0] w; logic inc; logic [4:0] th; logic clr;
    logic e, ae; logic [4:0] lvl, ptr; logic [3:0] addr; logic uf, pop;
  } vec_t;
  vec_t v[30];
  task automatic step();
    @(posedge rclk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction
  initial begin
    logic [4:0] wb, rb;
    int n;
    v[0]  = '{1, 7, 1, 2, 0, 1, 1, 0,  0,  0, 0, 0};
    v[1]  = '{1, 7, 1, 2, 0, 1, 1, 0,  0,  0, 0, 0};
    v[2]  = '{0, 1, 0, 2, 0, 1, 1, 0,  0,  0, 0, 0};
    v[3]  = '{0, 1, 0, 2, 0, 1, 1, 0,  0,  0, 0, 0};
    v[4]  = '{0, 1, 0, 2, 0, 0, 1, 1,  0,  0, 0, 0};
    v[5]  = '{0, 7, 0, 2, 0, 0, 1, 1,  0,  0, 0, 0};
    v[6]  = '{0, 7, 0, 2, 0, 0, 1, 1,  0,  0, 0, 0};
    v[7]  = '{0, 7, 0, 2, 0, 0, 0, 5,  0,  0, 0, 0};
    v[8]  = '{0, 7, 1, 2, 0, 0, 0, 4,  1,  1, 0, 1};
    v[9]  = '{0, 7, 1, 2, 0, 0, 0, 3,  3,  2, 0, 1};
    v[10] = '{0, 7, 1, 2, 0, 0, 1, 2,  2,  3, 0, 1};
    v[11] = '{0, 7, 1, 2, 0, 0, 1, 1,  6,  4, 0, 1};
    v[12] = '{0, 7, 1, 2, 0, 1, 1, 0,  7,  5, 0, 0};
    v[13] = '{0, 7, 1, 2, 0, 1, 1, 0,  7,  5, 1, 0};
    v[14] = '{0, 7, 1, 2, 1, 1, 1, 0,  7,  5, 1, 0};
    v[15] = '{0, 7, 0, 2, 1, 1, 1, 0,  7,  5, 0, 0};
    v[16] = '{0, 13, 0, 2, 0, 1, 1, 0, 7,  5, 0, 0};
    v[17] = '{0, 13, 0, 2, 0, 1, 1, 0, 7,  5, 0, 0};
    v[18] = '{0, 13, 0, 2, 0, 0, 0, 4, 7,  5, 0, 0};
    v[19] = '{0, 13, 1, 2, 0, 0, 0, 3, 5,  6, 0, 1};
    v[20] = '{0, 13, 1, 2, 0, 0, 1, 2, 4,  7, 0, 1};
    v[21] = '{0, 13, 1, 2, 0, 0, 1, 1, 12, 8, 0, 1};
    v[22] = '{0, 13, 1, 2, 0, 1, 1, 0, 13, 9, 0, 0};
    v[23] = '{0, 13, 0, 0, 0, 1, 1, 0, 13, 9, 0, 0};
    v[24] = '{0, 10, 0, 0, 0, 1, 1, 0, 13, 9, 0, 0};
    v[25] = '{0, 10, 0, 0, 0, 1, 1, 0, 13, 9, 0, 0};
    v[26] = '{0, 10, 0, 0, 0, 0, 0, 3, 13, 9, 0, 0};
    v[27] = '{0, 10, 1, 0, 0, 0, 0, 2, 15, 10, 0, 1};
    v[28] = '{1, 10, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0};
    v[29] = '{0, 0, 0, 0, 0, 1, 1, 0,  0,  0, 0, 0};
    rreset = 1; rinc = 0; clr_underflow = 0; wptr_async = 0; ae_thresh = 0;
    for (int i = 0; i < 30; i++) begin
      rreset = v[i].rst; wptr_async = v[i].w; rinc = v[i].inc;
      ae_thresh = v[i].th; clr_underflow = v[i].clr;
      step();
      chk($sformatf("v%0d rempty", i), rempty, v[i].e);
      chk($sformatf("v%0d ralmost_empty", i), ralmost_empty, v[i].ae);
      chk($sformatf("v%0d rlevel", i), rlevel, v[i].lvl);
      chk($sformatf("v%0d rptr", i), rptr, v[i].ptr);
      chk($sformatf("v%0d raddr", i), raddr, v[i].addr);
      chk($sformatf("v%0d runderflow", i), runderflow, v[i].uf);
      chk($sformatf("v%0d rpop", i), rpop, v[i].pop);
    end
    wb = 0; rb = 0;
    for (int i = 0; i < 27; i++) begin
      n = 1 + i % 2;
      for (int k = 0; k < n; k++) begin
        wb++;
        wptr_async = g(wb);
        step();
      end
      step(); step();
      chk($sformatf("wrap%0d rlevel", i), rlevel, n);
      chk($sformatf("wrap%0d rempty_fill", i), rempty, 0);
      rinc = 1;
      for (int k = 0; k < n; k++) step();
      rinc = 0;
      rb += 5'(n);
      chk($sformatf("wrap%0d rempty", i), rempty, 1);
      chk($sformatf("wrap%0d rlevel0", i), rlevel, 0);
      chk($sformatf("wrap%0d rptr", i), rptr, g(rb));
      chk($sformatf("wrap%0d raddr", i), raddr, rb[3:0]);
    end
    for (int k = 0; k < 16; k++) begin
      wb++;
      wptr_async = g(wb);
      step();
    end
    step(); step();
    chk("full rlevel", rlevel, 16);
    chk("full rempty", rempty, 0);
    chk("full ae_th0", ralmost_empty, 0);
    ae_thresh = 16;
    step();
    chk("full ae_th16", ralmost_empty, 1);
    rinc = 1;
    for (int k = 0; k < 16; k++) step();
    rinc = 0;
    chk("drain rempty", rempty, 1);
    chk("drain rlevel", rlevel, 0);
    chk("drain runderflow", runderflow, 0);
    chk("drain rptr", rptr, g(rb + 5'd16));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
